i2s_dac_tx: RTL and testbench
=============================

Name: i2s_dac_tx

Overview:
- Transmit end of the WM8731 digital audio interface, in I2S format. It is the counterpart of the ADC-side receiver.
- Accepts 32-bit stereo words {L[31:16], R[15:0]} from the DAC datapath through a valid/ready handshake and buffers them in a 2-entry FIFO.
- Serialises each word MSB-first onto AUD_DACDAT, timed by the codec-mastered AUD_BCLK and AUD_DACLRCK. All logic runs in the 50 MHz Clk domain.

Parameters:
- DATA_WIDTH, 16, bits per channel.
- SYNC_STAGES, 2, flip-flop stages on AUD_BCLK and AUD_DACLRCK.
- FIFO_DEPTH, 2, sample buffer entries (power of 2).

Ports:
- Clk  in  1  50 MHz system clock
- Reset_N  in  1  asynchronous, active-low reset
- ENABLE  in  1  transmit enable (tie to AUD_INIT_FINISH)
- AUD_BCLK  in  1  codec bit clock, asynchronous, at most Clk/4
- AUD_DACLRCK  in  1  codec frame clock, asynchronous; low = left channel
- SAMPLE_DATA  in  2*DATA_WIDTH  {left, right} sample
- SAMPLE_VALID  in  1  SAMPLE_DATA is valid
- SAMPLE_READY  out  1  FIFO can accept a word
- SAMPLE_REQ  out  1  one-Clk pulse when a word is popped for a new frame
- UNDERRUN  out  1  one-Clk pulse when a frame starts with the FIFO empty
- AUD_DACDAT  out  1  serial data to codec, registered

Behaviour:
- Reset values: AUD_DACDAT=0, SAMPLE_REQ=0, UNDERRUN=0, FIFO empty, state IDLE, synchroniser registers 0. SAMPLE_READY is derived from FIFO occupancy, so it reads 1 during and after reset.
- Synchronisation and edge detect:
  - AUD_BCLK and AUD_DACLRCK each pass through SYNC_STAGES flip-flops, plus one history register.
  - bclk_fall = prev & ~cur on synchronised BCLK.
  - lr_fall / lr_rise are detected the same way on synchronised LRCK.
- FIFO: a word is written when SAMPLE_VALID & SAMPLE_READY. SAMPLE_READY = (count != FIFO_DEPTH). Push and pop in the same cycle leave count unchanged.
- States:
  - IDLE: AUD_DACDAT=0. Go to DELAY on lr_fall when ENABLE=1. Always wait for a left frame start, never start mid-frame.
  - DELAY: hold AUD_DACDAT=0 for the I2S one-bit delay slot.
    - On the first bclk_fall, drive bit DATA_WIDTH-1 of the active channel, set bitcnt=DATA_WIDTH-1, go to SHIFT.
  - SHIFT: on each bclk_fall, drive the next lower bit and decrement bitcnt.
    - The bclk_fall after bit 0 drives 0 and goes to PAD.
  - PAD: AUD_DACDAT=0 until the next LRCK edge.
- Frame start (lr_fall while ENABLE=1, in any state other than IDLE, or in IDLE):
  - Pop the FIFO head into the frame register.
  - Pulse SAMPLE_REQ in the same cycle, whether or not the FIFO was empty.
  - If the FIFO is empty: load 0, pulse UNDERRUN, still proceed to DELAY.
- Channel switch: on lr_rise, select frame register [DATA_WIDTH-1:0] (right channel) and go to DELAY. There is no pop.
- Latency: MSB of a channel appears on AUD_DACDAT within SYNC_STAGES+2 Clk cycles after the first BCLK falling edge that follows the LRCK transition.
- Short frame: an LRCK edge while in SHIFT aborts the current channel, drops the remaining bits and starts the next channel (or frame) normally.
- ENABLE deasserted: go to IDLE in the next cycle, AUD_DACDAT=0, no pops. FIFO contents and writes are retained.
- Reset mid-frame: all state clears immediately (asynchronous). Restart on the next lr_fall after Reset_N deasserts.
- Simultaneous push and frame-start pop with the FIFO empty: the pop underruns (0 is sent) and the pushed word is stored for the next frame.

Decomposition:
- Package i2s_pkg: state enum (IDLE, DELAY, SHIFT, PAD), DATA_WIDTH default, FRAME_W = 2*DATA_WIDTH.
- One sub-module: sample_fifo (parameterised FIFO with count, push/pop, full/empty).
- Synchroniser: reuse the existing synchronizer module.

Test Plan:
- Single word: push 0xA5F0_0F5A, drive BCLK = Clk/16 with 32 BCLKs per LRCK period.
  - Left slot: 1 delay bit, then 1010010111110000, then zeros. Right slot: 0000111101011010. One SAMPLE_REQ pulse at lr_fall.
- Underrun: FIFO empty at lr_fall -> UNDERRUN and SAMPLE_REQ each pulse once; AUD_DACDAT=0 for the whole frame.
- Backpressure: push 3 words back-to-back -> SAMPLE_READY=0 after the 2nd push; the 3rd is accepted only after the next frame pop. Words are sent in push order.
- Short frame: 8 BCLKs per channel -> 7 MSBs sent after the delay slot, then a clean switch to the right channel; no hang.
- ENABLE drop mid-SHIFT -> AUD_DACDAT=0 next cycle. Re-enable -> transmission resumes only at the next lr_fall, with the FIFO word intact.
- Async reset mid-SHIFT -> all outputs 0 immediately; FIFO empty and SAMPLE_READY=1 afterwards.

Source files
------------

// File: rtl/i2s_pkg.sv
// Shared types and defaults for the I2S DAC transmit path.
package i2s_pkg;

   localparam int unsigned DEF_DATA_WIDTH = 16;
   localparam int unsigned DEF_FRAME_W    = 2 * DEF_DATA_WIDTH;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      DELAY = 2'd1,
      SHIFT = 2'd2,
      PAD   = 2'd3
   } state_e;

endpackage

// File: rtl/sample_fifo.sv
// Small power-of-two FIFO holding stereo sample words ahead of the serialiser.
module sample_fifo #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned DEPTH = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] wdata,
   output logic [WIDTH-1:0] rdata,
   output logic             full,
   output logic             empty
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [CW-1:0]    count;
   logic             do_push;
   logic             do_pop;

   assign full    = (count == CW'(DEPTH));
   assign empty   = (count == '0);
   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;
   assign rdata   = mem[rd_ptr];

   // Storage array; contents are don't-care while the FIFO is empty.
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr] <= wdata;
      end
   end

   // Pointers and occupancy; a pop on an empty FIFO is ignored.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         case ({do_push, do_pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/i2s_dac_tx.sv
// I2S transmitter toward the WM8731 DAC, clocked by the codec-mastered BCLK/LRCK.
module i2s_dac_tx
   import i2s_pkg::*;
#(
   parameter int unsigned DATA_WIDTH  = DEF_DATA_WIDTH,
   parameter int unsigned SYNC_STAGES = 2,
   parameter int unsigned FIFO_DEPTH  = 2
) (
   input  logic                    Clk,
   input  logic                    Reset_N,
   input  logic                    ENABLE,
   input  logic                    AUD_BCLK,
   input  logic                    AUD_DACLRCK,
   input  logic [2*DATA_WIDTH-1:0] SAMPLE_DATA,
   input  logic                    SAMPLE_VALID,
   output logic                    SAMPLE_READY,
   output logic                    SAMPLE_REQ,
   output logic                    UNDERRUN,
   output logic                    AUD_DACDAT
);

   localparam int unsigned FRAME_W = 2 * DATA_WIDTH;
   localparam int unsigned CNT_W   = $clog2(DATA_WIDTH);

   logic [SYNC_STAGES-1:0] bclk_sync;
   logic [SYNC_STAGES-1:0] lrck_sync;
   logic                   bclk_prev;
   logic                   lrck_prev;
   logic                   bclk_fall;
   logic                   lr_fall;
   logic                   lr_rise;

   logic                   fifo_full;
   logic                   fifo_empty;
   logic [FRAME_W-1:0]     fifo_head;
   logic                   frame_start;

   state_e                 state;
   logic [FRAME_W-1:0]     frame;
   logic [DATA_WIDTH-1:0]  shreg;
   logic [DATA_WIDTH-1:0]  active;
   logic [CNT_W-1:0]       bitcnt;
   logic                   chan_right;

   // Bring the codec clocks into the Clk domain and keep one sample of history.
   always_ff @(posedge Clk or negedge Reset_N) begin
      if (!Reset_N) begin
         bclk_sync <= '0;
         lrck_sync <= '0;
         bclk_prev <= 1'b0;
         lrck_prev <= 1'b0;
      end else begin
         bclk_sync <= {bclk_sync[SYNC_STAGES-2:0], AUD_BCLK};
         lrck_sync <= {lrck_sync[SYNC_STAGES-2:0], AUD_DACLRCK};
         bclk_prev <= bclk_sync[SYNC_STAGES-1];
         lrck_prev <= lrck_sync[SYNC_STAGES-1];
      end
   end

   assign bclk_fall = bclk_prev & ~bclk_sync[SYNC_STAGES-1];
   assign lr_fall   = lrck_prev & ~lrck_sync[SYNC_STAGES-1];
   assign lr_rise   = ~lrck_prev & lrck_sync[SYNC_STAGES-1];

   // A new left frame always consumes one FIFO slot, empty or not.
   assign frame_start  = ENABLE & lr_fall;
   assign SAMPLE_READY = ~fifo_full;
   assign active       = chan_right ? frame[DATA_WIDTH-1:0] : frame[FRAME_W-1:DATA_WIDTH];

   sample_fifo #(
      .WIDTH (FRAME_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (Clk),
      .rst_n (Reset_N),
      .push  (SAMPLE_VALID & SAMPLE_READY),
      .pop   (frame_start),
      .wdata (SAMPLE_DATA),
      .rdata (fifo_head),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   // Frame/channel sequencing and MSB-first serialisation on BCLK falling edges.
   always_ff @(posedge Clk or negedge Reset_N) begin
      if (!Reset_N) begin
         state      <= IDLE;
         frame      <= '0;
         shreg      <= '0;
         bitcnt     <= '0;
         chan_right <= 1'b0;
         AUD_DACDAT <= 1'b0;
         SAMPLE_REQ <= 1'b0;
         UNDERRUN   <= 1'b0;
      end else begin
         SAMPLE_REQ <= 1'b0;
         UNDERRUN   <= 1'b0;
         if (!ENABLE) begin
            state      <= IDLE;
            AUD_DACDAT <= 1'b0;
         end else if (lr_fall) begin
            frame      <= fifo_empty ? '0 : fifo_head;
            chan_right <= 1'b0;
            SAMPLE_REQ <= 1'b1;
            UNDERRUN   <= fifo_empty;
            state      <= DELAY;
            AUD_DACDAT <= 1'b0;
         end else if (lr_rise && (state != IDLE)) begin
            chan_right <= 1'b1;
            state      <= DELAY;
            AUD_DACDAT <= 1'b0;
         end else begin
            case (state)
               IDLE: begin
                  AUD_DACDAT <= 1'b0;
               end
               DELAY: begin
                  if (bclk_fall) begin
                     AUD_DACDAT <= active[DATA_WIDTH-1];
                     shreg      <= {active[DATA_WIDTH-2:0], 1'b0};
                     bitcnt     <= CNT_W'(DATA_WIDTH - 1);
                     state      <= SHIFT;
                  end
               end
               SHIFT: begin
                  if (bclk_fall) begin
                     if (bitcnt == '0) begin
                        AUD_DACDAT <= 1'b0;
                        state      <= PAD;
                     end else begin
                        AUD_DACDAT <= shreg[DATA_WIDTH-1];
                        shreg      <= {shreg[DATA_WIDTH-2:0], 1'b0};
                        bitcnt     <= bitcnt - CNT_W'(1);
                     end
                  end
               end
               PAD: begin
                  AUD_DACDAT <= 1'b0;
               end
               default: begin
                  state      <= IDLE;
                  AUD_DACDAT <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_i2s_dac_tx.sv
// Self-checking bench for i2s_dac_tx: drives a codec-style BCLK/LRCK and captures DACDAT.
module tb_i2s_dac_tx;

   localparam int HALF = 8;

   logic        Clk = 1'b0;
   logic        Reset_N;
   logic        ENABLE;
   logic        AUD_BCLK;
   logic        AUD_DACLRCK;
   logic [31:0] SAMPLE_DATA;
   logic        SAMPLE_VALID;
   logic        SAMPLE_READY;
   logic        SAMPLE_REQ;
   logic        UNDERRUN;
   logic        AUD_DACDAT;

   int checks  = 0;
   int errors  = 0;
   int req_cnt = 0;
   int und_cnt = 0;
   int acc_cnt = 0;

   logic [31:0] mq [$];

   typedef struct {
      int          n;
      bit          do_push;
      logic [31:0] word;
      bit          exp_under;
   } vec_t;

   vec_t tbl [5];

   i2s_dac_tx dut (
      .Clk          (Clk),
      .Reset_N      (Reset_N),
      .ENABLE       (ENABLE),
      .AUD_BCLK     (AUD_BCLK),
      .AUD_DACLRCK  (AUD_DACLRCK),
      .SAMPLE_DATA  (SAMPLE_DATA),
      .SAMPLE_VALID (SAMPLE_VALID),
      .SAMPLE_READY (SAMPLE_READY),
      .SAMPLE_REQ   (SAMPLE_REQ),
      .UNDERRUN     (UNDERRUN),
      .AUD_DACDAT   (AUD_DACDAT)
   );

   always #10 Clk = ~Clk;

   // Pulse and handshake counters.
   always @(posedge Clk) begin
      if (SAMPLE_REQ) req_cnt++;
      if (UNDERRUN) und_cnt++;
      if (SAMPLE_VALID && SAMPLE_READY) acc_cnt++;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Codec-side sample of DACDAT at BCLK rise k: slot 0 is the delay bit, then MSB first, then zeros.
   function automatic logic [31:0] exp_slot(input logic [15:0] d, input int n);
      logic [31:0] e;
      e = '0;
      for (int k = 1; k < n && k < 32; k++) begin
         if (k <= 16) e[k] = d[16-k];
      end
      return e;
   endfunction

   task automatic run_slot(input logic lr, input int n, output logic [31:0] cap);
      cap = '0;
      for (int b = 0; b < n; b++) begin
         @(negedge Clk);
         AUD_BCLK = 1'b0;
         if (b == 0) AUD_DACLRCK = lr;
         repeat (HALF - 1) @(negedge Clk);
         @(negedge Clk);
         if (b < 32) cap[b] = AUD_DACDAT;
         AUD_BCLK = 1'b1;
         repeat (HALF - 1) @(negedge Clk);
      end
   endtask

   task automatic push_word(input logic [31:0] w);
      @(negedge Clk);
      chk("ready before push", 32'(SAMPLE_READY), 32'd1);
      SAMPLE_VALID = 1'b1;
      SAMPLE_DATA  = w;
      @(negedge Clk);
      SAMPLE_VALID = 1'b0;
      mq.push_back(w);
   endtask

   task automatic do_frame(input int n, input bit exp_under, input string tag);
      logic [31:0] w;
      logic [31:0] cl;
      logic [31:0] cr;
      int          r0;
      int          u0;
      if (mq.size() == 0) w = 32'h0;
      else w = mq.pop_front();
      r0 = req_cnt;
      u0 = und_cnt;
      run_slot(1'b0, n, cl);
      run_slot(1'b1, n, cr);
      chk({tag, " left"}, cl, exp_slot(w[31:16], n));
      chk({tag, " right"}, cr, exp_slot(w[15:0], n));
      chk({tag, " req pulses"}, 32'(req_cnt - r0), 32'd1);
      chk({tag, " underrun pulses"}, 32'(und_cnt - u0), 32'(exp_under));
   endtask

   initial begin
      #(20 * 200000);
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      logic [31:0] cl;
      logic [31:0] cr;
      int          r0;
      int          a0;
      int          np;
      int          n;

      tbl[0] = '{32, 1'b1, 32'hA5F0_0F5A, 1'b0};
      tbl[1] = '{32, 1'b0, 32'h0000_0000, 1'b1};
      tbl[2] = '{8,  1'b1, 32'h1234_5678, 1'b0};
      tbl[3] = '{20, 1'b1, 32'hC3A5_5A3C, 1'b0};
      tbl[4] = '{16, 1'b1, 32'hFFFF_0001, 1'b0};

      Reset_N      = 1'b0;
      ENABLE       = 1'b1;
      AUD_BCLK     = 1'b1;
      AUD_DACLRCK  = 1'b1;
      SAMPLE_DATA  = '0;
      SAMPLE_VALID = 1'b0;
      repeat (4) @(negedge Clk);
      chk("reset dacdat", 32'(AUD_DACDAT), 32'd0);
      chk("reset req", 32'(SAMPLE_REQ), 32'd0);
      chk("reset underrun", 32'(UNDERRUN), 32'd0);
      chk("reset ready", 32'(SAMPLE_READY), 32'd1);
      Reset_N = 1'b1;
      repeat (8) @(negedge Clk);

      // Table-driven frames: single word, underrun, short frames, 16-BCLK slot.
      for (int i = 0; i < 5; i++) begin
         if (tbl[i].do_push) push_word(tbl[i].word);
         do_frame(tbl[i].n, tbl[i].exp_under, $sformatf("vec%0d", i));
      end

      // Backpressure: third word waits for the next frame pop; push order preserved.
      push_word(32'h1111_AAAA);
      chk("ready after 1st push", 32'(SAMPLE_READY), 32'd1);
      push_word(32'h2222_BBBB);
      chk("ready after 2nd push", 32'(SAMPLE_READY), 32'd0);
      a0 = acc_cnt;
      @(negedge Clk);
      SAMPLE_VALID = 1'b1;
      SAMPLE_DATA  = 32'h3333_CCCC;
      repeat (4) @(negedge Clk);
      chk("held word not accepted", 32'(acc_cnt - a0), 32'd0);
      fork
         do_frame(32, 1'b0, "bp frame1");
         begin
            int k;
            k = 0;
            @(negedge Clk);
            while (!SAMPLE_READY && k < 1000) begin
               @(negedge Clk);
               k++;
            end
            chk("bp ready wait", 32'(k < 1000), 32'd1);
            if (k < 1000) begin
               @(negedge Clk);
               SAMPLE_VALID = 1'b0;
               mq.push_back(32'h3333_CCCC);
            end else begin
               SAMPLE_VALID = 1'b0;
            end
            chk("bp 3rd accepted once", 32'(acc_cnt - a0), 32'd1);
         end
      join
      do_frame(32, 1'b0, "bp frame2");
      do_frame(32, 1'b0, "bp frame3");

      // ENABLE drop mid-SHIFT, then re-enable; second word must survive.
      push_word(32'hFFFF_FFFF);
      push_word(32'h5A5A_C3C3);
      void'(mq.pop_front());
      r0 = req_cnt;
      fork
         run_slot(1'b0, 32, cl);
         begin
            repeat (5 * 16 + 4) @(negedge Clk);
            chk("dacdat before enable drop", 32'(AUD_DACDAT), 32'd1);
            ENABLE = 1'b0;
            @(negedge Clk);
            chk("dacdat after enable drop", 32'(AUD_DACDAT), 32'd0);
         end
      join
      chk("left with enable drop", cl, 32'h0000_001E);
      fork
         run_slot(1'b1, 32, cr);
         begin
            repeat (3 * 16) @(negedge Clk);
            ENABLE = 1'b1;
         end
      join
      chk("right while idle", cr, 32'h0);
      chk("req during disabled frame", 32'(req_cnt - r0), 32'd1);
      do_frame(32, 1'b0, "resume");

      // Asynchronous reset mid-SHIFT with the FIFO full.
      push_word(32'hFFFF_FFFF);
      void'(mq.pop_front());
      fork
         run_slot(1'b0, 32, cl);
         begin
            repeat (20) @(negedge Clk);
            push_word(32'h0BAD_F00D);
            push_word(32'h0DEF_ACED);
            chk("full before reset", 32'(SAMPLE_READY), 32'd0);
            repeat (5 * 16 + 4 - 24) @(negedge Clk);
            chk("dacdat before reset", 32'(AUD_DACDAT), 32'd1);
            #3;
            Reset_N = 1'b0;
            #1;
            chk("dacdat in reset", 32'(AUD_DACDAT), 32'd0);
            chk("req in reset", 32'(SAMPLE_REQ), 32'd0);
            chk("underrun in reset", 32'(UNDERRUN), 32'd0);
            chk("ready in reset", 32'(SAMPLE_READY), 32'd1);
            repeat (3) @(negedge Clk);
            Reset_N = 1'b1;
            mq.delete();
         end
      join
      chk("left with reset", cl, 32'h0000_001E);
      run_slot(1'b1, 32, cr);
      chk("right after reset", cr, 32'h0);
      do_frame(32, 1'b1, "post-reset");

      // Randomized frames against the queue model.
      for (int i = 0; i < 6; i++) begin
         np = $urandom_range(0, 2 - mq.size());
         for (int j = 0; j < np; j++) push_word($urandom);
         n = $urandom_range(8, 32);
         do_frame(n, mq.size() == 0, $sformatf("rand%0d n=%0d", i, n));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
